// File: rtl/instruction_fetch.sv
// Single-stage instruction fetch: PC register plus IF/ID pipeline register.
// Optional illegal-fetch trap is enabled by defining FETCH_ILLEGAL_TRAP_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_word,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, p4_q, p4_d;
  logic        valid_q, valid_d;
  logic        fault_q;
  logic        illegal;
  logic [31:0] pc_inc;

  assign pc_inc = pc_q + 32'd4;

`ifdef FETCH_ILLEGAL_TRAP_EN
  logic fault_d;
  assign illegal = (imem_word == 32'hFFFF_FFFF);
`else
  assign illegal = 1'b0;
  assign fault_q = 1'b0;
`endif

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    p4_d    = p4_q;
    valid_d = valid_q;
`ifdef FETCH_ILLEGAL_TRAP_EN
    fault_d = fault_q;
`endif
    if (fault_q) begin
      // trapped: everything frozen until reset
    end else if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      instr_d = 32'h0;
      ipc_d   = pc_q;
      p4_d    = pc_inc;
      valid_d = 1'b0;
    end else if (flush) begin
      pc_d    = pc_inc;
      instr_d = 32'h0;
      ipc_d   = pc_q;
      p4_d    = pc_inc;
      valid_d = 1'b0;
    end else if (stall) begin
      // hold
    end else if (illegal) begin
      // PC stays on the faulting address for debug visibility
      instr_d = 32'h0;
      ipc_d   = pc_q;
      p4_d    = pc_inc;
      valid_d = 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
      fault_d = 1'b1;
`endif
    end else begin
      pc_d    = pc_inc;
      instr_d = imem_word;
      ipc_d   = pc_q;
      p4_d    = pc_inc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      p4_q    <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      p4_q    <= p4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`endif

  assign imem_addr   = pc_q;
  assign if_instr    = instr_q;
  assign if_pc       = ipc_q;
  assign if_pc_plus4 = p4_q;
  assign if_valid    = valid_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: two instances (reset PC 0 and 0xFFFF_FFFC),
// a behavioural model pushes expected IF/ID state, popped after each edge.
module tb_instruction_fetch;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] p4;
    logic        valid;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        zero_b = 1'b0;
  logic [31:0] zero_w = 32'h0;

  logic [31:0] imem_addr, imem_word, if_instr, if_pc, if_pc_plus4;
  logic        if_valid, fetch_fault;
  logic [31:0] imem_addr2, imem_word2, if_instr2, if_pc2, if_pc_plus42;
  logic        if_valid2, fetch_fault2;

  int n_chk = 0, n_fail = 0;
  exp_t q1[$], q2[$];
  exp_t m1 = '0, m2 = '0;
  bit   m_ok = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0)  return 32'h2400_0120;
    if (a == 32'h40) return 32'hFFFF_FFFF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb imem_word  = word_at(imem_addr);
  always_comb imem_word2 = word_at(imem_addr2);

  instruction_fetch #(.RESET_PC(RST_A)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_word(imem_word), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
    .fetch_fault(fetch_fault));

  instruction_fetch #(.RESET_PC(RST_B)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(zero_b), .flush(zero_b),
    .redirect_valid(zero_b), .redirect_pc(zero_w),
    .imem_addr(imem_addr2), .imem_word(imem_word2), .if_instr(if_instr2),
    .if_pc(if_pc2), .if_pc_plus4(if_pc_plus42), .if_valid(if_valid2),
    .fetch_fault(fetch_fault2));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic exp_t nxt(input exp_t s, input logic [31:0] rpc0,
                               input logic r, st, fl, rv, input logic [31:0] rpc);
    exp_t n = s;
    logic [31:0] w = word_at(s.pc);
    if (!r) n = '{pc: rpc0, default: '0};
`ifdef FETCH_ILLEGAL_TRAP_EN
    else if (s.fault) n = s;
`endif
    else if (rv) n = '{pc: {rpc[31:2], 2'b00}, instr: 32'h0, ipc: s.pc, p4: s.pc + 4, valid: 1'b0, fault: 1'b0};
    else if (fl) n = '{pc: s.pc + 4, instr: 32'h0, ipc: s.pc, p4: s.pc + 4, valid: 1'b0, fault: 1'b0};
    else if (st) n = s;
`ifdef FETCH_ILLEGAL_TRAP_EN
    else if (w == 32'hFFFF_FFFF) n = '{pc: s.pc, instr: 32'h0, ipc: s.pc, p4: s.pc + 4, valid: 1'b0, fault: 1'b1};
`endif
    else n = '{pc: s.pc + 4, instr: w, ipc: s.pc, p4: s.pc + 4, valid: 1'b1, fault: 1'b0};
    return n;
  endfunction

  task automatic cmp(input string p, input exp_t e, input logic [31:0] a, i, pc, p4,
                     input logic v, f);
    check({p, "imem_addr"}, a, e.pc);
    check({p, "if_instr"}, i, e.instr);
    check({p, "if_pc"}, pc, e.ipc);
    check({p, "if_pc_plus4"}, p4, e.p4);
    check({p, "if_valid"}, {31'h0, v}, {31'h0, e.valid});
    check({p, "fetch_fault"}, {31'h0, f}, {31'h0, e.fault});
  endtask

  task automatic step(input logic r, st, fl, rv, input logic [31:0] rpc);
    exp_t e;
    rst_n = r; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
    #1;
    if (m_ok) begin
      check("pre_imem_addr", imem_addr, m1.pc);
      check("pre_imem_addr2", imem_addr2, m2.pc);
    end
    q1.push_back(nxt(m1, RST_A, r, st, fl, rv, rpc));
    q2.push_back(nxt(m2, RST_B, r, 1'b0, 1'b0, 1'b0, 32'h0));
    @(posedge clk); #1;
    e = q1.pop_front(); m1 = e;
    cmp("a.", e, imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, fetch_fault);
    e = q2.pop_front(); m2 = e;
    cmp("b.", e, imem_addr2, if_instr2, if_pc2, if_pc_plus42, if_valid2, fetch_fault2);
    if (!r) m_ok = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h44);
    check("rst_valid", {31'h0, if_valid}, 32'h0);
    check("rst_addr_b", imem_addr2, 32'hFFFF_FFFC);

    // first released edge captures the word at RESET_PC
    run(1);
    check("first_instr", if_instr, 32'h2400_0120);
    check("first_pc", if_pc, 32'h0);
    check("first_p4", if_pc_plus4, 32'h4);
    check("first_valid", {31'h0, if_valid}, 32'h1);
    check("first_addr", imem_addr, 32'h4);
    check("wrap_pc_b", if_pc2, 32'hFFFF_FFFC);
    check("wrap_p4_b", if_pc_plus42, 32'h0);
    check("wrap_addr_b", imem_addr2, 32'h0);

    run(3);
    check("seq_pc", if_pc, 32'hC);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_addr", imem_addr, 32'h10);
      check("stall_pc", if_pc, 32'hC);
    end
    run(1);
    check("post_stall_pc", if_pc, 32'h10);
    run(3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h83);
    check("redir_addr", imem_addr, 32'h80);
    check("redir_valid", {31'h0, if_valid}, 32'h0);
    run(1);
    check("redir_pc", if_pc, 32'h80);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check("flush_instr", if_instr, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    run(1);

    // walk into the all-ones word at 0x40
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h3E);
    run(2);
`ifdef FETCH_ILLEGAL_TRAP_EN
    check("trap_fault", {31'h0, fetch_fault}, 32'h1);
    check("trap_valid", {31'h0, if_valid}, 32'h0);
    check("trap_addr", imem_addr, 32'h40);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    check("trap_redir_ignored", imem_addr, 32'h40);
`else
    check("pass_instr", if_instr, 32'hFFFF_FFFF);
    check("pass_valid", {31'h0, if_valid}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    check("pass_redir", imem_addr, 32'h100);
`endif
    run(2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_fault", {31'h0, fetch_fault}, 32'h0);
    run(3);
    check("rerun_pc", if_pc, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
